if_fetch_unit: RTL

//   Instruction-fetch front end. Owns the PC and drives the read side of the

---
 rtl/if_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the instruction ROM and queues
// fetched words for decode, with redirect flushes and a misaligned-target fault marker.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        if_misalign_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {RUN, MISAL, HALT} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        misalign;
    } entry_t;

    entry_t          queue_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fetch_pc_q;
    state_t          state_q, state_d;

    entry_t head, entry_in;
    logic   pop, space, misal_push, push;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        head       = queue_q[rd_ptr_q];
        if_valid_o = ~rst & ~redirect_i & (count_q != '0);
        pop        = if_valid_o & id_ready_i;
        space      = (count_q < DEPTH_C) | pop;
        rom_en     = ~rst & ~redirect_i & space & (state_q == RUN);
        misal_push = ~rst & ~redirect_i & space & (state_q == MISAL);
        push       = rom_en | misal_push;
        rom_addr   = rst ? RESET_PC : fetch_pc_q;

        entry_in = misal_push ? '{inst: NOP_INST,   pc: fetch_pc_q, misalign: 1'b1}
                              : '{inst: rom_inst_i, pc: fetch_pc_q, misalign: 1'b0};

        if_inst_o     = if_valid_o ? head.inst     : 32'h0;
        if_pc_o       = if_valid_o ? head.pc       : 32'h0;
        if_misalign_o = if_valid_o ? head.misalign : 1'b0;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Redirect outranks everything; a misaligned target parks the FSM after one marker.
        state_d = state_q;
        if (redirect_i)
            state_d = (redirect_pc_i[1:0] == 2'b00) ? RUN : MISAL;
        else if (misal_push)
            state_d = HALT;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state.
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= RUN;
        end else if (redirect_i) begin
            fetch_pc_q <= redirect_pc_i;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= state_d;
        end else begin
            if (rom_en)
                fetch_pc_q <= fetch_pc_q + 32'd4;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // NOTE: queue storage is not reset; count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (push)
            queue_q[wr_ptr_q] <= entry_in;
    end

endmodule
